// File: rtl/sorted_stream_emitter.sv
// Output stage for the N-input sorting/median networks: captures one sorted vector per handshake,
// streams it out beat by beat (all elements or the median only) and self-checks its ordering.
module sorted_stream_emitter #(
  parameter int unsigned N     = 11,
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][W-1:0]   sort,
  input  logic                  median_only,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [3:0]            out_index,
  output logic                  out_last,
  output logic                  order_err,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [3:0] MedIdx  = 4'(N / 2);
  localparam logic [3:0] LastIdx = 4'(N - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e               state_q, state_d;
  logic [N-1:0][W-1:0]  buffer_q;
  logic [3:0]           index_q;
  logic                 last_q;
  logic                 order_err_q;
  logic [CNT_W-1:0]     err_count_q;

  logic                 capture;
  logic                 final_xfer;
  logic                 viol;

  // Any descending neighbour pair means the upstream network misbehaved.
  always_comb begin
    viol = 1'b0;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (sort[i] > sort[i+1]) viol = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (capture) state_d = StEmit;
      StEmit: if (final_xfer && !capture) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / handshake logic; in_ready opens on the final beat so frames run back to back.
  always_comb begin
    out_valid  = (state_q == StEmit);
    final_xfer = out_valid && out_ready && last_q;
    in_ready   = !rst && ((state_q == StIdle) || final_xfer);
    capture    = in_valid && in_ready;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q    <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
      order_err_q <= 1'b0;
      err_count_q <= '0;
    end else if (capture) begin
      buffer_q    <= sort;
      index_q     <= median_only ? MedIdx : 4'd0;
      last_q      <= median_only;
      order_err_q <= viol;
      if (viol && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
    end else if (out_valid && out_ready) begin
      if (last_q) begin
        index_q     <= '0;
        last_q      <= 1'b0;
        order_err_q <= 1'b0;
      end else begin
        index_q <= index_q + 4'd1;
        last_q  <= ((index_q + 4'd1) == LastIdx);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (index_q == 4'(i)) out_data = buffer_q[i];
    end
  end

  assign out_index = index_q;
  assign out_last  = last_q;
  assign order_err = order_err_q;
  assign err_count = err_count_q;

endmodule
